// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared types and constants for the multi-channel LED driver
package led_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_PATTERN = 2'd3
   } led_mode_t;

   localparam int PATTERN_LEN = 32;
   localparam int IDX_BITS    = 5;

endpackage

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one LED channel: config registers, step timer and base level
module led_channel
   import led_pattern_pkg::*;
#(
   parameter int PWM_BITS    = 8,
   parameter int PERIOD_BITS = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tick,
   input  logic                   load,
   input  led_mode_t              cfg_mode,
   input  logic [PERIOD_BITS-1:0] cfg_period,
   input  logic [PWM_BITS-1:0]    cfg_bright,
   input  logic [PATTERN_LEN-1:0] cfg_pattern,
   output logic                   base,
   output logic [PWM_BITS-1:0]    bright
);

   led_mode_t              mode;
   logic [PERIOD_BITS-1:0] period;
   logic [PATTERN_LEN-1:0] pattern;
   logic [PERIOD_BITS-1:0] step_cnt;
   logic [PERIOD_BITS-1:0] step_max;
   logic [IDX_BITS-1:0]    idx;
   logic                   level;

   // A zero period behaves like a period of one tick.
   assign step_max = (period == '0) ? '0 : period - PERIOD_BITS'(1);

   // A load restarts the phase and takes priority over a coincident tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode     <= MODE_OFF;
         period   <= PERIOD_BITS'(1);
         bright   <= '1;
         pattern  <= '0;
         step_cnt <= '0;
         idx      <= '0;
         level    <= 1'b1;
      end else if (load) begin
         mode     <= cfg_mode;
         period   <= cfg_period;
         bright   <= cfg_bright;
         pattern  <= cfg_pattern;
         step_cnt <= '0;
         idx      <= '0;
         level    <= 1'b1;
      end else if (tick) begin
         if (step_cnt >= step_max) begin
            step_cnt <= '0;
            if (mode == MODE_BLINK) begin
               level <= ~level;
            end
            if (mode == MODE_PATTERN) begin
               idx <= idx + 1'b1;
            end
         end else begin
            step_cnt <= step_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      base = 1'b0;
      case (mode)
         MODE_OFF:     base = 1'b0;
         MODE_ON:      base = 1'b1;
         MODE_BLINK:   base = level;
         MODE_PATTERN: base = pattern[idx];
         default:      base = 1'b0;
      endcase
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - top: prescaler, PWM counter, config handshake and LED output register
module led_pattern_ctrl
   import led_pattern_pkg::*;
#(
   parameter int CLK_HZ      = 16_000_000,
   parameter int TICK_HZ     = 1000,
   parameter int CHANNELS    = 1,
   parameter int PWM_BITS    = 8,
   parameter int PERIOD_BITS = 16
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   CFG_VALID,
   output logic                   CFG_READY,
   input  logic [2:0]             CFG_CHAN,
   input  logic [1:0]             CFG_MODE,
   input  logic [PERIOD_BITS-1:0] CFG_PERIOD,
   input  logic [PWM_BITS-1:0]    CFG_BRIGHT,
   input  logic [PATTERN_LEN-1:0] CFG_PATTERN,
   output logic [CHANNELS-1:0]    LED,
   output logic                   USBPU
);

   localparam int DIV        = CLK_HZ / TICK_HZ;
   localparam int PRESC_BITS = $clog2(DIV);
   localparam logic [PRESC_BITS-1:0] PRESC_MAX = PRESC_BITS'(DIV - 1);

   logic [PRESC_BITS-1:0]  presc;
   logic                   tick;
   logic [PWM_BITS-1:0]    pwm_cnt;
   logic                   cfg_ready;
   logic                   accept;
   logic                   stage_valid;
   logic [2:0]             stage_chan;
   led_mode_t              stage_mode;
   logic [PERIOD_BITS-1:0] stage_period;
   logic [PWM_BITS-1:0]    stage_bright;
   logic [PATTERN_LEN-1:0] stage_pattern;
   logic [CHANNELS-1:0]    load;
   logic [CHANNELS-1:0]    base;
   logic [CHANNELS-1:0]    pwm_on;
   logic [PWM_BITS-1:0]    bright [CHANNELS];

   assign tick      = (presc == PRESC_MAX);
   assign accept    = CFG_VALID & cfg_ready;
   assign CFG_READY = cfg_ready;
   assign USBPU     = 1'b0;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         presc   <= '0;
         pwm_cnt <= '0;
      end else begin
         presc   <= tick ? '0 : presc + 1'b1;
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   // Accepted config is staged for one cycle; ready drops in that cycle.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cfg_ready     <= 1'b1;
         stage_valid   <= 1'b0;
         stage_chan    <= '0;
         stage_mode    <= MODE_OFF;
         stage_period  <= '0;
         stage_bright  <= '0;
         stage_pattern <= '0;
      end else begin
         cfg_ready   <= ~accept;
         stage_valid <= accept;
         if (accept) begin
            stage_chan    <= CFG_CHAN;
            stage_mode    <= led_mode_t'(CFG_MODE);
            stage_period  <= CFG_PERIOD;
            stage_bright  <= CFG_BRIGHT;
            stage_pattern <= CFG_PATTERN;
         end
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      assign load[c]   = stage_valid && (stage_chan == 3'(c));
      assign pwm_on[c] = (&bright[c]) | (pwm_cnt < bright[c]);

      led_channel #(
         .PWM_BITS    (PWM_BITS),
         .PERIOD_BITS (PERIOD_BITS)
      ) u_chan (
         .clk         (CLK),
         .rst_n       (RESET_N),
         .tick        (tick),
         .load        (load[c]),
         .cfg_mode    (stage_mode),
         .cfg_period  (stage_period),
         .cfg_bright  (stage_bright),
         .cfg_pattern (stage_pattern),
         .base        (base[c]),
         .bright      (bright[c])
      );
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         LED <= '0;
      end else begin
         LED <= base & pwm_on;
      end
   end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - self-checking bench for led_pattern_ctrl (tick every 10 cycles, 2 channels)
module tb_led_pattern_ctrl;

   localparam logic [1:0] M_OFF = 2'd0;
   localparam logic [1:0] M_ON  = 2'd1;
   localparam logic [1:0] M_BLK = 2'd2;
   localparam logic [1:0] M_PAT = 2'd3;

   logic        clk;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [2:0]  cfg_chan;
   logic [1:0]  cfg_mode;
   logic [15:0] cfg_period;
   logic [7:0]  cfg_bright;
   logic [31:0] cfg_pattern;
   logic [1:0]  led;
   logic        usbpu;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [2:0]  chan;
      logic [1:0]  mode;
      logic [15:0] period;
      logic [7:0]  bright;
      logic [31:0] pattern;
      int          window;
      int          exp0;
      int          exp1;
   } vec_t;

   vec_t vecs[11];

   led_pattern_ctrl #(
      .CLK_HZ      (1000),
      .TICK_HZ     (100),
      .CHANNELS    (2),
      .PWM_BITS    (8),
      .PERIOD_BITS (16)
   ) dut (
      .CLK         (clk),
      .RESET_N     (rst_n),
      .CFG_VALID   (cfg_valid),
      .CFG_READY   (cfg_ready),
      .CFG_CHAN    (cfg_chan),
      .CFG_MODE    (cfg_mode),
      .CFG_PERIOD  (cfg_period),
      .CFG_BRIGHT  (cfg_bright),
      .CFG_PATTERN (cfg_pattern),
      .LED         (led),
      .USBPU       (usbpu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising edges since reset release; edge k carries a prescaler tick when k % 10 == 0.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Returns at the first falling edge after the accepting rising edge.
   task automatic send(input logic [2:0] chan, input logic [1:0] mode, input logic [15:0] period,
                       input logic [7:0] bright, input logic [31:0] pattern);
      int n;
      n = 0;
      @(negedge clk);
      cfg_chan = chan; cfg_mode = mode; cfg_period = period;
      cfg_bright = bright; cfg_pattern = pattern; cfg_valid = 1'b1;
      while (!cfg_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) check("send_ready_timeout", 0, 1);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic count_high(input int n, output int h0, output int h1);
      h0 = 0;
      h1 = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         h0 += int'(led[0]);
         h1 += int'(led[1]);
      end
   endtask

   task automatic wait_led1(input logic v, input string name);
      int n;
      n = 0;
      while (led[1] !== v && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check(name, int'(led[1]), int'(v));
   endtask

   task automatic run_len(input logic v, output int len);
      len = 0;
      while (led[1] === v && len < 500) begin
         len++;
         @(negedge clk);
      end
   endtask

   // Accept edge lands at cycle number with (edge % 10) == off; predicts the first blink toggle.
   task automatic tick_case(input int off, input string name);
      int e0, s;
      repeat (3) @(negedge clk);
      while (((cyc + 1) % 10) != off) @(negedge clk);
      cfg_chan = 3'd1; cfg_mode = M_BLK; cfg_period = 16'd3;
      cfg_bright = 8'hFF; cfg_pattern = 32'd0; cfg_valid = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      cfg_valid = 1'b0;
      s = e0 + 2;
      while ((s % 10) != 0) s++;
      s += 20;
      while (cyc < e0 + 11) @(negedge clk);
      check({name, "_early_high"}, int'(led[1]), 1);
      while (cyc < s) @(negedge clk);
      check({name, "_before_toggle"}, int'(led[1]), 1);
      @(negedge clk);
      check({name, "_after_toggle"}, int'(led[1]), 0);
   endtask

   initial begin
      int h0, h1, len;

      vecs[0]  = '{3'd1, M_OFF, 16'd1, 8'hFF, 32'h0,          256,  256, 0};
      vecs[1]  = '{3'd0, M_ON,  16'd1, 8'h40, 32'h0,          256,  64,  0};
      vecs[2]  = '{3'd0, M_ON,  16'd1, 8'h00, 32'h0,          256,  0,   0};
      vecs[3]  = '{3'd0, M_ON,  16'd1, 8'h80, 32'h0,          512,  256, 0};
      vecs[4]  = '{3'd1, M_ON,  16'd1, 8'h01, 32'h0,          256,  128, 1};
      vecs[5]  = '{3'd1, M_OFF, 16'd1, 8'hFF, 32'h0,          256,  128, 0};
      vecs[6]  = '{3'd0, M_PAT, 16'd1, 8'hFF, 32'h0000_0005,  320,  20,  0};
      vecs[7]  = '{3'd1, M_BLK, 16'd1, 8'hFF, 32'h0,          320,  20,  160};
      vecs[8]  = '{3'd0, M_PAT, 16'd2, 8'h40, 32'hFFFF_FFFF,  1280, 320, 640};
      vecs[9]  = '{3'd5, M_ON,  16'd1, 8'hFF, 32'h0,          1280, 320, 640};
      vecs[10] = '{3'd1, M_BLK, 16'd0, 8'hFF, 32'h0,          1280, 320, 640};

      rst_n = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_mode = '0;
      cfg_period = '0; cfg_bright = '0; cfg_pattern = '0;
      repeat (3) @(negedge clk);
      check("reset_led", int'(led), 0);
      check("reset_ready", int'(cfg_ready), 1);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_led", int'(led), 0);
      check("post_reset_ready", int'(cfg_ready), 1);
      check("usbpu", int'(usbpu), 0);
      count_high(1000, h0, h1);
      check("idle_led0_high", h0, 0);
      check("idle_led1_high", h1, 0);

      send(3'd0, M_ON, 16'd1, 8'hFF, 32'd0);
      check("on_lat_edge1", int'(led[0]), 0);
      @(negedge clk);
      check("on_lat_edge2_pre", int'(led[0]), 0);
      @(negedge clk);
      check("on_lat_edge2", int'(led[0]), 1);
      count_high(300, h0, h1);
      check("on_led0_high", h0, 300);
      check("on_led1_high", h1, 0);

      send(3'd1, M_BLK, 16'd3, 8'hFF, 32'd0);
      wait_led1(1'b1, "blink_rise_timeout");
      wait_led1(1'b0, "blink_fall_timeout");
      run_len(1'b0, len);
      check("blink_low_run", len, 30);
      run_len(1'b1, len);
      check("blink_high_run", len, 30);
      run_len(1'b0, len);
      check("blink_low_run2", len, 30);
      check("blink_ch0_kept", int'(led[0]), 1);

      for (int i = 0; i < 11; i++) begin
         send(vecs[i].chan, vecs[i].mode, vecs[i].period, vecs[i].bright, vecs[i].pattern);
         repeat (20) @(negedge clk);
         count_high(vecs[i].window, h0, h1);
         check($sformatf("vec%0d_led0", i), h0, vecs[i].exp0);
         check($sformatf("vec%0d_led1", i), h1, vecs[i].exp1);
      end

      repeat (3) @(negedge clk);
      cfg_chan = 3'd6; cfg_mode = M_ON; cfg_bright = 8'hFF; cfg_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("held_valid_ready%0d", i), int'(cfg_ready), (i % 2 == 0) ? 1 : 0);
         @(negedge clk);
      end
      cfg_valid = 1'b0;

      tick_case(0, "tick_on_accept");
      tick_case(9, "tick_on_load");

      wait_led1(1'b1, "midblink_timeout");
      #2 rst_n = 1'b0;
      #1 check("midblink_reset_led", int'(led), 0);
      check("midblink_reset_ready", int'(cfg_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      @(negedge clk);
      cfg_chan = 3'd0; cfg_mode = M_ON; cfg_bright = 8'hFF; cfg_period = 16'd1; cfg_valid = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      cfg_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      count_high(100, h0, h1);
      check("pending_discard_led0", h0, 0);
      check("pending_discard_led1", h1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
